// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scan decoder:
// segment patterns (g..a), special nibble codes and the lap-tracking state enum.
package seg_scan_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [3:0] NIB_BLANK   = 4'hA;
    localparam logic [3:0] NIB_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DARK = 2'd2
    } scan_state_t;

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] d);
        case (d)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational seven-segment (g..a) to nibble decoder.
// Define SEG_DECODE_HEX_EN to also accept the A-F glyphs; otherwise they decode as invalid.
module seg7_to_nibble
    import seg_scan_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        nibble  = NIB_INVALID;
        invalid = 1'b1;
        case (segments)
            SEG_BLANK: begin nibble = NIB_BLANK; invalid = 1'b0; end
            SEG_0:     begin nibble = 4'h0;      invalid = 1'b0; end
            SEG_1:     begin nibble = 4'h1;      invalid = 1'b0; end
            SEG_2:     begin nibble = 4'h2;      invalid = 1'b0; end
            SEG_3:     begin nibble = 4'h3;      invalid = 1'b0; end
            SEG_4:     begin nibble = 4'h4;      invalid = 1'b0; end
            SEG_5:     begin nibble = 4'h5;      invalid = 1'b0; end
            SEG_6:     begin nibble = 4'h6;      invalid = 1'b0; end
            SEG_7:     begin nibble = 4'h7;      invalid = 1'b0; end
            SEG_8:     begin nibble = 4'h8;      invalid = 1'b0; end
            SEG_9:     begin nibble = 4'h9;      invalid = 1'b0; end
`ifdef SEG_DECODE_HEX_EN
            SEG_A:     begin nibble = 4'hA;      invalid = 1'b0; end
            SEG_B:     begin nibble = 4'hB;      invalid = 1'b0; end
            SEG_C:     begin nibble = 4'hC;      invalid = 1'b0; end
            SEG_D:     begin nibble = 4'hD;      invalid = 1'b0; end
            SEG_E:     begin nibble = 4'hE;      invalid = 1'b0; end
            SEG_F:     begin nibble = 4'hF;      invalid = 1'b0; end
`else
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the value shown on a 4-digit multiplexed seven-segment display by
// sampling its segment/digit drive lines, debouncing each digit and assembling laps into frames.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DARK_TIMEOUT  = 4096
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic [7:0]  i_Segments,
    input  logic [3:0]  i_Digits,
    output logic [15:0] o_Value,
    output logic [3:0]  o_Dots,
    output logic [3:0]  o_Mask,
    output logic        o_Frame_Stb,
    output logic        o_Code_Err,
    output logic        o_Proto_Err
);

    localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYCLES);
    localparam logic [15:0] DARK_LAST  = 16'(DARK_TIMEOUT - 1);

    logic [7:0]  seg_q;
    logic [3:0]  dig_q;
    logic [7:0]  prev_seg;
    logic [3:0]  prev_dig;
    logic [7:0]  settle_cnt;
    logic [7:0]  settle_next;
    logic [15:0] dark_cnt;
    logic        multi_q;
    scan_state_t state;

    logic [15:0] lap_value;
    logic [3:0]  lap_dots;
    logic [3:0]  lap_mask;
    logic [1:0]  prev_idx;

    logic        digit_valid;
    logic        multi_hot;
    logic        changed;
    logic        capture;
    logic        boundary;
    logic        timeout;
    logic [1:0]  idx;
    logic [3:0]  cap_nibble;
    logic        cap_invalid;
    logic [15:0] frame_value;
    logic [3:0]  frame_dots;

    seg7_to_nibble u_decode (
        .segments (seg_q[6:0]),
        .nibble   (cap_nibble),
        .invalid  (cap_invalid)
    );

    // Multi-hot enables count as "no digit": they never capture and they feed the dark timer.
    assign digit_valid = is_onehot(dig_q);
    assign multi_hot   = (dig_q != 4'd0) && !digit_valid;
    assign idx         = digit_index(dig_q);
    assign changed     = (dig_q != prev_dig) || (seg_q != prev_seg);

    // Counter saturates at the limit so a steady digit is captured exactly once.
    assign settle_next = changed                   ? 8'd1 :
                         (settle_cnt == SETTLE_LIM) ? settle_cnt : settle_cnt + 8'd1;
    assign capture     = digit_valid && (settle_next == SETTLE_LIM)
                         && (changed || (settle_cnt != SETTLE_LIM));
    assign boundary    = capture && (state == ST_SCAN) && (idx <= prev_idx);
    assign timeout     = (state == ST_SCAN) && !digit_valid && (dark_cnt == DARK_LAST);

    always_comb begin
        frame_value = o_Value;
        frame_dots  = o_Dots;
        for (int k = 0; k < 4; k++) begin
            if (lap_mask[k]) begin
                frame_value[k*4 +: 4] = lap_value[k*4 +: 4];
                frame_dots[k]         = lap_dots[k];
            end
        end
    end

    // NOTE: lap contents carry no reset; lap_mask alone says which entries are meaningful.
    always_ff @(posedge i_Clock) begin
        if (capture) begin
            lap_value[{idx, 2'b00} +: 4] <= cap_nibble;
            lap_dots[idx]                <= seg_q[7];
        end
    end

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            seg_q       <= '0;
            dig_q       <= '0;
            prev_seg    <= '0;
            prev_dig    <= '0;
            settle_cnt  <= '0;
            dark_cnt    <= '0;
            multi_q     <= 1'b0;
            state       <= ST_IDLE;
            lap_mask    <= '0;
            prev_idx    <= '0;
            o_Value     <= 16'hAAAA;
            o_Dots      <= '0;
            o_Mask      <= '0;
            o_Frame_Stb <= 1'b0;
            o_Code_Err  <= 1'b0;
            o_Proto_Err <= 1'b0;
        end else begin
            seg_q       <= i_Segments;
            dig_q       <= i_Digits;
            prev_seg    <= seg_q;
            prev_dig    <= dig_q;
            settle_cnt  <= settle_next;
            multi_q     <= multi_hot;
            o_Proto_Err <= multi_hot && !multi_q;
            o_Code_Err  <= capture && cap_invalid;
            o_Frame_Stb <= 1'b0;

            if ((state == ST_SCAN) && !digit_valid && !timeout)
                dark_cnt <= dark_cnt + 16'd1;
            else
                dark_cnt <= '0;

            if (capture) begin
                prev_idx <= idx;
                state    <= ST_SCAN;
                if (boundary) begin
                    o_Value     <= frame_value;
                    o_Dots      <= frame_dots;
                    o_Mask      <= lap_mask;
                    o_Frame_Stb <= 1'b1;
                    lap_mask    <= 4'b0001 << idx;
                end else begin
                    lap_mask    <= lap_mask | (4'b0001 << idx);
                end
            end else if (timeout) begin
                o_Mask      <= '0;
                o_Frame_Stb <= 1'b1;
                lap_mask    <= '0;
                state       <= ST_DARK;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a cycle-level reference model pushes expected
// frames as stimulus is driven; a monitor pops and compares them on every o_Frame_Stb.
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int DARK   = 4096;
    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_DARK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [15:0] o_Value;
    logic [3:0]  o_Dots;
    logic [3:0]  o_Mask;
    logic        o_Frame_Stb;
    logic        o_Code_Err;
    logic        o_Proto_Err;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .DARK_TIMEOUT  (DARK)
    ) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Segments  (seg),
        .i_Digits    (dig),
        .o_Value     (o_Value),
        .o_Dots      (o_Dots),
        .o_Mask      (o_Mask),
        .o_Frame_Stb (o_Frame_Stb),
        .o_Code_Err  (o_Code_Err),
        .o_Proto_Err (o_Proto_Err)
    );

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  mask;
    } frame_t;

    frame_t exp_q[$];

    logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_cmp = 0;
    int n_bad = 0;
    int stb_count = 0;
    int code_count = 0;
    int proto_count = 0;

    // Reference model state
    logic [15:0] m_value = 16'hAAAA;
    logic [3:0]  m_dots = 4'h0;
    logic [15:0] m_lap_value = 16'h0;
    logic [3:0]  m_lap_dots = 4'h0;
    logic [3:0]  m_lap_mask = 4'h0;
    int          m_state = M_IDLE;
    int          m_prev = 0;
    int          m_run = 0;
    logic [3:0]  m_last_d = 4'h0;
    logic [7:0]  m_last_s = 8'h0;
    bit          m_prev_multi = 1'b0;
    int          m_idle = 0;
    int          exp_frames = 0;
    int          exp_code = 0;
    int          exp_proto = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int v, input bit dot);
        logic [6:0] p;
        p = seg_tab[v];
        return {dot, p};
    endfunction

    task automatic ref_decode(input logic [6:0] p, output logic [3:0] nib, output bit err);
        int top;
`ifdef SEG_DECODE_HEX_EN
        top = 15;
`else
        top = 9;
`endif
        nib = 4'hF;
        err = 1'b1;
        if (p == 7'd0) begin
            nib = 4'hA;
            err = 1'b0;
        end else begin
            for (int k = 0; k <= top; k++) begin
                if (seg_tab[k] == p) begin
                    nib = 4'(k);
                    err = 1'b0;
                end
            end
        end
    endtask

    task automatic push_frame(input logic [3:0] mask);
        frame_t f;
        f.value = m_value;
        f.dots  = m_dots;
        f.mask  = mask;
        exp_q.push_back(f);
        exp_frames++;
    endtask

    task automatic model_capture(input int idx, input logic [7:0] s);
        logic [3:0] nib;
        bit err;
        ref_decode(s[6:0], nib, err);
        if (err) exp_code++;
        if (m_state == M_SCAN && idx <= m_prev) begin
            for (int k = 0; k < 4; k++) begin
                if (m_lap_mask[k]) begin
                    m_value[k*4 +: 4] = m_lap_value[k*4 +: 4];
                    m_dots[k]         = m_lap_dots[k];
                end
            end
            push_frame(m_lap_mask);
            m_lap_mask = 4'h0;
        end
        m_lap_value[idx*4 +: 4] = nib;
        m_lap_dots[idx]         = s[7];
        m_lap_mask[idx]         = 1'b1;
        m_prev  = idx;
        m_state = M_SCAN;
    endtask

    task automatic model_cycle(input logic [3:0] d, input logic [7:0] s);
        bit onehot;
        bit multi;
        int idx;
        onehot = (d == 4'b0001) || (d == 4'b0010) || (d == 4'b0100) || (d == 4'b1000);
        multi  = (d != 4'h0) && !onehot;
        idx    = d[3] ? 3 : d[2] ? 2 : d[1] ? 1 : 0;
        if (d != m_last_d || s != m_last_s) m_run = 1;
        else if (m_run < 100000) m_run++;
        m_last_d = d;
        m_last_s = s;
        if (multi && !m_prev_multi) exp_proto++;
        m_prev_multi = multi;
        if (onehot && m_run == SETTLE) model_capture(idx, s);
        if (m_state == M_SCAN && !onehot) begin
            m_idle++;
            if (m_idle == DARK) begin
                push_frame(4'h0);
                m_lap_mask = 4'h0;
                m_state    = M_DARK;
                m_idle     = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
        for (int c = 0; c < n; c++) begin
            dig = d;
            seg = s;
            model_cycle(d, s);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        dig   = 4'h0;
        seg   = 8'h0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        m_value      = 16'hAAAA;
        m_dots       = 4'h0;
        m_lap_mask   = 4'h0;
        m_state      = M_IDLE;
        m_prev       = 0;
        m_run        = 0;
        m_last_d     = 4'h0;
        m_last_s     = 8'h0;
        m_prev_multi = 1'b0;
        m_idle       = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, o_Value, 16'hAAAA);
        check({tag, "_dots"},  o_Dots,  4'h0);
        check({tag, "_mask"},  o_Mask,  4'h0);
        check({tag, "_pulses"}, {o_Frame_Stb, o_Code_Err, o_Proto_Err}, 3'b000);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        frame_t e;
        if (o_Code_Err === 1'b1) code_count++;
        if (o_Proto_Err === 1'b1) proto_count++;
        if (o_Frame_Stb === 1'b1) begin
            stb_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_stb", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_value", o_Value, e.value);
                check("frame_dots",  o_Dots,  e.dots);
                check("frame_mask",  o_Mask,  e.mask);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        dig   = 4'h0;
        seg   = 8'h0;
        @(negedge clk);
        do_reset(3);
        check_reset_outputs("reset");

        // Two full laps of 1,2,3,4 on digits 3..0, scanned from digit 0 upward.
        for (int lap = 0; lap < 2; lap++) begin
            drive(4'b0001, glyph(4, 0), 8);
            drive(4'b0010, glyph(3, 0), 8);
            drive(4'b0100, glyph(2, 0), 8);
            drive(4'b1000, glyph(1, 0), 8);
        end
        drive(4'b0000, 8'h00, 3);
        drain("two_lap_drain");
        check("two_lap_strobes", stb_count, 1);

        // Digit 2 only flashes for two cycles and must not appear in the frame.
        drive(4'b0001, glyph(8, 0), 8);
        drive(4'b0010, glyph(7, 1), 8);
        drive(4'b0100, glyph(6, 0), 2);
        drive(4'b1000, glyph(5, 0), 8);
        drive(4'b0001, glyph(9, 0), 8);
        drain("glitch_drain");
        check("glitch_mask_bit2", o_Mask[2], 1'b0);

        // Multi-hot enables, blank digit and the A glyph.
        drive(4'b0101, glyph(3, 0), 3);
        drive(4'b0010, 8'h00, 8);
        drive(4'b0100, glyph(10, 0), 8);
        drive(4'b1000, glyph(0, 0), 8);
        drive(4'b0001, glyph(1, 0), 8);
        drain("code_drain");
        check("proto_count", proto_count, exp_proto);
        check("code_count", code_count, exp_code);

        // Dark timeout: one empty frame, then silence.
        drive(4'b0000, 8'h00, DARK + 4);
        drain("dark_drain");
        drive(4'b0000, 8'h00, 300);
        check("dark_strobes", stb_count, exp_frames);

        // Reset in the middle of a lap discards it without a strobe.
        drive(4'b0100, glyph(3, 0), 8);
        drive(4'b1000, glyph(2, 0), 8);
        drive(4'b0000, 8'h00, 3);
        check("pre_reset_strobes", stb_count, exp_frames);
        do_reset(3);
        check_reset_outputs("mid_reset");
        check("mid_reset_queue", exp_q.size(), 0);
        drive(4'b0001, glyph(9, 0), 8);
        drive(4'b0010, glyph(8, 0), 8);
        drive(4'b0100, glyph(7, 1), 8);
        drive(4'b1000, glyph(6, 0), 8);
        drive(4'b0001, glyph(0, 0), 8);
        drain("final_drain");

        check("total_strobes", stb_count, exp_frames);
        check("total_code_err", code_count, exp_code);
        check("total_proto_err", proto_count, exp_proto);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
